// File: rtl/lifo_stream_rd.sv
// Read-side stage for the LIFO: pops len_i words through the 1-cycle-latency
// rdreq/q port and streams them newest-first on a registered valid/ready output.
module lifo_stream_rd #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              lifo_empty_i,
  input  logic              lifo_wrreq_i,
  output logic              lifo_rdreq_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [AWIDTH:0] LEN_ZERO = '0;
  localparam logic [AWIDTH:0] LEN_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [AWIDTH:0]   left_q;
  logic              inflight_q;
  logic              done_q, done_set;
  logic              busy, rdreq;

  // Two-entry buffer: the output register is the head, the skid register the tail.
  logic              out_valid_q, skid_valid_q;
  logic [DWIDTH-1:0] out_data_q, skid_data_q;

  logic              pop;
  logic [1:0]        occ;
  logic [2:0]        fill_after;

  assign pop        = out_valid_q & src_ready_i;
  assign occ        = 2'(out_valid_q) + 2'(skid_valid_q);
  assign fill_after = 3'(occ) + 3'(inflight_q) - 3'(pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i && (len_i != LEN_ZERO)) state_d = ST_RUN;
      ST_RUN:   if (rdreq && (left_q == LEN_ONE))   state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q && (occ == 2'd0))   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reads are held off under a write because the LIFO drops rdreq in that cycle.
  always_comb begin
    busy     = 1'b0;
    rdreq    = 1'b0;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: done_set = start_i && (len_i == LEN_ZERO);
      ST_RUN: begin
        busy  = 1'b1;
        rdreq = (left_q != LEN_ZERO) && !lifo_empty_i && !lifo_wrreq_i &&
                (fill_after < 3'd2);
      end
      ST_DRAIN: begin
        busy     = 1'b1;
        done_set = !inflight_q && (occ == 2'd0);
      end
      default: ;
    endcase
  end

  assign busy_o       = busy;
  assign lifo_rdreq_o = rdreq;
  assign done_o       = done_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      left_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= rdreq;
      done_q     <= done_set;
      if ((state_q == ST_IDLE) && start_i) left_q <= len_i;
      else if (rdreq)                      left_q <= left_q - LEN_ONE;
    end
  end

  // Head register: valid and data are visible flops on the stream port.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      case ({inflight_q, pop})
        2'b10: begin
          if (!out_valid_q) begin
            out_data_q  <= lifo_q_i;
            out_valid_q <= 1'b1;
          end else begin
            skid_valid_q <= 1'b1;
          end
        end
        2'b01: begin
          if (skid_valid_q) begin
            out_data_q   <= skid_data_q;
            skid_valid_q <= 1'b0;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        2'b11: begin
          if (skid_valid_q) out_data_q <= skid_data_q;
          else              out_data_q <= lifo_q_i;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the skid data register is storage qualified by skid_valid_q, so it
  // carries no reset; only the control bits and the visible output are reset.
  always_ff @(posedge clk_i) begin
    if (inflight_q && (out_valid_q || skid_valid_q) && !(pop && !skid_valid_q))
      skid_data_q <= lifo_q_i;
  end

  assign src_data_o  = out_data_q;
  assign src_valid_o = out_valid_q;

endmodule
